// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin sharing of one single-port on-chip RAM
// (8192 x 32, byte-enabled) between NUM_MASTERS Avalon-MM requesters.
// One access is forwarded per cycle. Read data returns one cycle after acceptance.
// Optional build macro: ONCHIP_ARB_LOCK_EN adds m_lock for exclusive bus locking.
module onchip_mem_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_chipselect,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
`ifdef ONCHIP_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]          m_lock,
`endif
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [NUM_MASTERS-1:0]          m_readdatavalid,
  output logic [DATA_W-1:0]               m_readdata,
  output logic                            mem_chipselect,
  output logic                            mem_write,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [DATA_W/8-1:0]             mem_byteenable,
  output logic [DATA_W-1:0]               mem_writedata,
  output logic                            mem_clken,
  input  logic [DATA_W-1:0]               mem_readdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] grant;
  logic                   grant_vld;
  idx_t                   grant_idx;
  idx_t                   cand_idx;
  idx_t                   last_grant;
  logic                   accept_rd;
  logic                   rd_vld;
  idx_t                   rd_idx;

  logic [ADDR_W-1:0] addr_arr [NUM_MASTERS];
  logic [BE_W-1:0]   be_arr   [NUM_MASTERS];
  logic [DATA_W-1:0] wd_arr   [NUM_MASTERS];

  // Unpack the per-master request buses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      addr_arr[i] = m_address[i*ADDR_W +: ADDR_W];
      be_arr[i]   = m_byteenable[i*BE_W +: BE_W];
      wd_arr[i]   = m_writedata[i*DATA_W +: DATA_W];
    end
  end

  // Requests are ignored entirely while reset is held.
  assign req = reset ? '0 : m_chipselect;

`ifdef ONCHIP_ARB_LOCK_EN
  logic lock_active;
  idx_t lock_owner;

  // A held lock restricts eligibility to its owner.
  always_comb begin
    eligible = req;
    if (lock_active) begin
      eligible = req & (NUM_MASTERS'(1) << lock_owner);
    end
  end

  // Lock acquire/release tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_owner  <= '0;
    end else if (grant_vld && m_lock[grant_idx]) begin
      lock_active <= 1'b1;
      lock_owner  <= grant_idx;
    end else if (lock_active && grant_vld && (grant_idx == lock_owner)) begin
      lock_active <= 1'b0;
    end else if (lock_active && !req[lock_owner] && !m_lock[lock_owner]) begin
      lock_active <= 1'b0;
    end
  end
`else
  assign eligible = req;
`endif

  // Round-robin search starting just after the last granted index.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      cand_idx = idx_t'((32'(last_grant) + off) % NUM_MASTERS);
      if (!grant_vld && eligible[cand_idx]) begin
        grant_vld       = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  assign m_waitrequest = m_chipselect & ~grant;
  assign accept_rd     = grant_vld & ~m_write[grant_idx];

  // Forward the granted master's access to the RAM; park the bus at zero when idle.
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (grant_vld) begin
      mem_chipselect = 1'b1;
      mem_write      = m_write[grant_idx];
      mem_address    = addr_arr[grant_idx];
      mem_byteenable = be_arr[grant_idx];
      mem_writedata  = wd_arr[grant_idx];
    end
  end

  assign mem_clken  = 1'b1;
  assign m_readdata = mem_readdata;

  // Round-robin pointer and one-deep read-return tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= idx_t'(NUM_MASTERS - 1);
      rd_vld     <= 1'b0;
      rd_idx     <= '0;
    end else begin
      rd_vld <= accept_rd;
      if (grant_vld) begin
        last_grant <= grant_idx;
      end
      if (accept_rd) begin
        rd_idx <= grant_idx;
      end
    end
  end

  // Steer the return pulse to the master that issued the read.
  always_comb begin
    m_readdatavalid         = '0;
    m_readdatavalid[rd_idx] = rd_vld;
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_wait_only_req: assert property (@(posedge clk) disable iff (reset)
    (m_waitrequest & ~m_chipselect) == '0);

endmodule
